vpu_fp_max_reduce_ctrl: RTL

- Sequencer for the BF16 max-compare datapath (combinational; 2 or 3 operands in, 1 result out).
- Accepts a reduction command of N elements and streams operand beats (1–2 elements per beat) from the SRAM read ports.
- Drives the datapath with a running-max accumulator plus the new elements, then returns the final maximum on a valid/ready result port.

---
 rtl/vpu_fp_max_reduce_ctrl_pkg.sv | 21 ++
 rtl/vpu_bf16_nan_det.sv | 13 +
 rtl/vpu_fp_max_reduce_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vpu_fp_max_reduce_ctrl_pkg.sv
// Shared definitions for the BF16 max-reduction sequencer.
//   OPERAND_WIDTH   : element width (BF16)
//   LEN_WIDTH       : width of the element-count field
//   SRAM_R_PORT_CNT : number of datapath operand slots
//   max_red_state_t : sequencer state encoding
//   BF16_QNAN       : canonical quiet NaN returned when a NaN was consumed
package vpu_fp_max_reduce_ctrl_pkg;

    localparam int OPERAND_WIDTH   = 16;
    localparam int LEN_WIDTH       = 16;
    localparam int SRAM_R_PORT_CNT = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } max_red_state_t;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/vpu_bf16_nan_det.sv
// Combinational NaN detector for one BF16 element.
//   elem   : BF16 element under test
//   is_nan : high when the exponent is all ones and the mantissa is non-zero
module vpu_bf16_nan_det
    import vpu_fp_max_reduce_ctrl_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] elem,
    output logic                     is_nan
);

    assign is_nan = (elem[14:7] == 8'hFF) && (elem[6:0] != 7'd0);

endmodule

// File: rtl/vpu_fp_max_reduce_ctrl.sv
// Sequencer for the combinational BF16 max-compare datapath. Accepts a
// reduction command of cmd_len elements, consumes operand beats of one or
// two elements, folds them into a running maximum through the external
// datapath and returns the final maximum on a valid/ready result port.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   cmd_valid/ready/len   : command handshake and element count
//   in_valid/ready        : operand beat handshake
//   in_data_0/1, in_cnt   : beat elements; in_cnt=1 means two elements
//   dp_en, dp_op_0/1/2    : datapath enable and operands
//   dp_op_valid           : operand participation mask (bit 2 = op_2)
//   dp_result             : datapath result, same cycle
//   out_valid/ready/data  : reduced-maximum result handshake
//   busy                  : sequencer not idle
//   nan_flag              : sticky NaN indication for the current command
//
// Optional feature: define VPU_FP_MAX_NAN_CHK_EN to enable NaN checking of
// every consumed element; a NaN forces the result to the canonical quiet NaN.
// Without it nan_flag is tied low and the result is the raw accumulator.
module vpu_fp_max_reduce_ctrl #(
    parameter int OPERAND_WIDTH   = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int SRAM_R_PORT_CNT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPERAND_WIDTH-1:0]   in_data_0,
    input  logic [OPERAND_WIDTH-1:0]   in_data_1,
    input  logic                       in_cnt,
    output logic                       dp_en,
    output logic [OPERAND_WIDTH-1:0]   dp_op_0,
    output logic [OPERAND_WIDTH-1:0]   dp_op_1,
    output logic [OPERAND_WIDTH-1:0]   dp_op_2,
    output logic [SRAM_R_PORT_CNT-1:0] dp_op_valid,
    input  logic [OPERAND_WIDTH-1:0]   dp_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPERAND_WIDTH-1:0]   out_data,
    output logic                       busy,
    output logic                       nan_flag
);

    import vpu_fp_max_reduce_ctrl_pkg::*;

    max_red_state_t             state_reg, state_next;
    logic [OPERAND_WIDTH-1:0]   acc_reg;
    logic [LEN_WIDTH-1:0]       rem_reg;
    logic                       first_reg;

    logic                       cmd_fire;
    logic                       in_fire;
    logic                       two_used;
    logic                       last_beat;
    logic [LEN_WIDTH-1:0]       used_cnt;
    logic [OPERAND_WIDTH-1:0]   done_data;

    assign cmd_fire  = (state_reg == IDLE) && cmd_valid;
    assign in_fire   = (state_reg == ACCUM) && in_valid;
    // The second element only counts while at least two remain, so rem
    // can never underflow on a trailing two-element beat.
    assign two_used  = in_cnt && (rem_reg >= LEN_WIDTH'(2));
    assign used_cnt  = two_used ? LEN_WIDTH'(2) : LEN_WIDTH'(1);
    assign last_beat = (rem_reg == used_cnt);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic; operands are zero unless a beat is actually consumed.
    always_comb begin
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        dp_en       = 1'b0;
        dp_op_0     = '0;
        dp_op_1     = '0;
        dp_op_2     = '0;
        dp_op_valid = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            ACCUM: begin
                in_ready = 1'b1;
                dp_en    = 1'b1;
                if (in_valid) begin
                    if (first_reg) begin
                        // No accumulator yet: seed the compare from the beat itself.
                        dp_op_0     = in_data_0;
                        dp_op_1     = two_used ? in_data_1 : in_data_0;
                        dp_op_valid = SRAM_R_PORT_CNT'(3'b011);
                    end else begin
                        dp_op_0     = acc_reg;
                        dp_op_1     = in_data_0;
                        dp_op_2     = two_used ? in_data_1 : '0;
                        dp_op_valid = two_used ? SRAM_R_PORT_CNT'(3'b111)
                                               : SRAM_R_PORT_CNT'(3'b011);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = done_data;
            end
            default: ;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Accumulator, remaining count and first-beat marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            rem_reg   <= '0;
            first_reg <= 1'b0;
        end else if (cmd_fire) begin
            acc_reg   <= '0;
            rem_reg   <= cmd_len;
            first_reg <= 1'b1;
        end else if (in_fire) begin
            acc_reg   <= dp_result;
            rem_reg   <= rem_reg - used_cnt;
            first_reg <= 1'b0;
        end
    end

`ifdef VPU_FP_MAX_NAN_CHK_EN
    logic                     nan_reg;
    logic [1:0]               elem_nan;
    logic [OPERAND_WIDTH-1:0] chk_elem [2];
    logic                     nan_hit;

    assign chk_elem[0] = in_data_0;
    assign chk_elem[1] = in_data_1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nan_det
            vpu_bf16_nan_det u_nan_det (
                .elem   (chk_elem[gi]),
                .is_nan (elem_nan[gi])
            );
        end
    endgenerate

    // An ignored second element (rem==1) must not raise the flag.
    assign nan_hit = in_fire && (elem_nan[0] || (two_used && elem_nan[1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_reg <= 1'b0;
        end else if (cmd_fire) begin
            nan_reg <= 1'b0;
        end else if (nan_hit) begin
            nan_reg <= 1'b1;
        end
    end

    assign nan_flag  = nan_reg;
    assign done_data = nan_reg ? OPERAND_WIDTH'(BF16_QNAN) : acc_reg;
`else
    assign nan_flag  = 1'b0;
    assign done_data = acc_reg;
`endif

endmodule
